// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch front-end and the downstream counter stage.
package stopwatch_pkg;

  // Mode codes seen by the counter/display stage.
  typedef enum logic [2:0] {
    ST_RESET = 3'b001,
    ST_COUNT = 3'b010,
    ST_PAUSE = 3'b011,
    ST_STOP  = 3'b100
  } state_t;

  // The single winning press event of a cycle after priority resolution.
  typedef enum logic [2:0] {
    EV_NONE  = 3'd0,
    EV_RESET = 3'd1,
    EV_STOP  = 3'd2,
    EV_PAUSE = 3'd3,
    EV_COUNT = 3'd4
  } event_t;

  localparam int unsigned CLK_HZ = 50_000_000;

  // Resolve simultaneous presses: Reset > Stop > Pause > Count.
  function automatic event_t encode_event(input logic ev_reset, input logic ev_stop,
                                          input logic ev_pause, input logic ev_count);
    event_t ev;
    if (ev_reset) begin
      ev = EV_RESET;
    end else if (ev_stop) begin
      ev = EV_STOP;
    end else if (ev_pause) begin
      ev = EV_PAUSE;
    end else if (ev_count) begin
      ev = EV_COUNT;
    end else begin
      ev = EV_NONE;
    end
    return ev;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronizer + debouncer for one push button; emits a one-cycle pulse on
// each accepted press (0->1 acceptance). Releases are accepted silently.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive cycles of disagreement; accept the new level after
  // DEBOUNCE_CYCLES of them. The >= guard keeps the counter from ever wrapping.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = CNT_ZERO;
    press_d  = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = CNT_ZERO;
    end else if (cnt_q >= CNT_MAX) begin
      stable_d = sync2_q;
      cnt_d    = CNT_ZERO;
      press_d  = sync2_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Debounce state and registered press pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_q <= 1'b0;
      cnt_q    <= CNT_ZERO;
      press_q  <= 1'b0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign level = stable_q;
  assign press = press_q;

endmodule

// File: rtl/stopwatch_button_fsm.sv
// Stopwatch front-end: debounced button events drive the mode FSM whose
// registered state code feeds the counter/display stage.
module stopwatch_button_fsm
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ButtonStart,
  input  logic       ButtonReset,
  input  logic       ButtonCount,
  input  logic       ButtonPause,
  input  logic       ButtonStop,
  output logic [2:0] state,
  output logic       state_changed
);

  // Bit order: 0 Reset, 1 Count, 2 Pause, 3 Stop.
  logic [3:0] buttons_s;
  logic [3:0] press_s;
  logic [3:0] levels_unused_s;

  logic   start_sync1_q, start_sync2_q;
  state_t state_q, state_d;
  logic   state_changed_q, state_changed_d;
  event_t ev_s;

  assign buttons_s = {ButtonStop, ButtonPause, ButtonCount, ButtonReset};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clk  (clk),
      .rst  (rst),
      .din  (buttons_s[i]),
      .level(levels_unused_s[i]),
      .press(press_s[i])
    );
  end

  // Start switch is a level: synchronize only, no debounce.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_sync1_q <= 1'b0;
      start_sync2_q <= 1'b0;
    end else begin
      start_sync1_q <= ButtonStart;
      start_sync2_q <= start_sync1_q;
    end
  end

  // Next-state logic: Start low forces RESET and discards events; an
  // unexpected state code also recovers to RESET.
  always_comb begin
    ev_s    = encode_event(press_s[0], press_s[3], press_s[2], press_s[1]);
    state_d = state_q;
    if (!start_sync2_q) begin
      state_d = ST_RESET;
    end else if (!(state_q inside {ST_RESET, ST_COUNT, ST_PAUSE, ST_STOP})) begin
      state_d = ST_RESET;
    end else begin
      case (ev_s)
        EV_RESET: state_d = ST_RESET;
        EV_STOP:  state_d = ST_STOP;
        EV_PAUSE: begin
          if (state_q == ST_COUNT) begin
            state_d = ST_PAUSE;
          end else begin
            state_d = state_q;
          end
        end
        EV_COUNT: begin
          if ((state_q == ST_RESET) || (state_q == ST_PAUSE)) begin
            state_d = ST_COUNT;
          end else begin
            state_d = state_q;
          end
        end
        default:  state_d = state_q;
      endcase
    end
    state_changed_d = (state_d != state_q);
  end

  // Mode register and change pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_RESET;
      state_changed_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      state_changed_q <= state_changed_d;
    end
  end

  assign state         = state_q;
  assign state_changed = state_changed_q;

endmodule

// File: tb/tb_stopwatch_button_fsm.sv
// Self-checking bench: directed scenarios plus random button activity, all
// compared every cycle against a history-window reference model.
module tb_stopwatch_button_fsm;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] btn = 4'b0000;   // 0 Reset, 1 Count, 2 Pause, 3 Stop
  logic [2:0] state;
  logic       state_changed;

  stopwatch_button_fsm #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .ButtonStart  (start),
    .ButtonReset  (btn[0]),
    .ButtonCount  (btn[1]),
    .ButtonPause  (btn[2]),
    .ButtonStop   (btn[3]),
    .state        (state),
    .state_changed(state_changed)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int pulses   = 0;

  // Reference model: modes as plain integers, inputs kept as raw history.
  localparam int M_RESET = 0, M_COUNT = 1, M_PAUSE = 2, M_STOP = 3;
  logic [3:0] raw_hist[$];
  logic       start_hist[$];
  int         m_state;
  logic       m_changed;
  logic [3:0] m_stable;
  logic [3:0] m_ev;

  function automatic logic [2:0] code_of(input int m);
    case (m)
      M_COUNT: return 3'b010;
      M_PAUSE: return 3'b011;
      M_STOP:  return 3'b100;
      default: return 3'b001;
    endcase
  endfunction

  // Raw button value applied before edge i (edges counted from 1 after reset).
  function automatic logic [3:0] raw_at(input int i);
    if (i < 1 || i > raw_hist.size()) return 4'b0000;
    return raw_hist[i-1];
  endfunction

  function automatic logic start_at(input int i);
    if (i < 1 || i > start_hist.size()) return 1'b0;
    return start_hist[i-1];
  endfunction

  function automatic void model_reset();
    raw_hist.delete();
    start_hist.delete();
    m_state   = M_RESET;
    m_changed = 1'b0;
    m_stable  = 4'b0000;
    m_ev      = 4'b0000;
  endfunction

  // Advance the model by one clock edge. A press is accepted at edge k when
  // the synchronized value (raw delayed two edges) disagreed with the
  // accepted level for the D edges before it.
  function automatic void model_edge();
    int         k;
    int         nxt;
    logic       ssync;
    logic [3:0] ev_new;
    logic [3:0] r;
    logic       differ;
    k      = raw_hist.size() + 1;
    nxt    = m_state;
    ssync  = start_at(k - 2);
    ev_new = 4'b0000;
    if (!ssync) nxt = M_RESET;
    else if (m_ev[0]) nxt = M_RESET;
    else if (m_ev[3]) nxt = M_STOP;
    else if (m_ev[2]) begin
      if (m_state == M_COUNT) nxt = M_PAUSE;
    end else if (m_ev[1]) begin
      if (m_state == M_RESET || m_state == M_PAUSE) nxt = M_COUNT;
    end
    m_changed = (nxt != m_state);
    m_state   = nxt;
    for (int b = 0; b < 4; b++) begin
      differ = 1'b1;
      for (int i = k - 1 - D; i <= k - 2; i++) begin
        r = raw_at(i);
        if (r[b] == m_stable[b]) differ = 1'b0;
      end
      if (differ) begin
        m_stable[b] = ~m_stable[b];
        ev_new[b]   = m_stable[b];
      end
    end
    m_ev = ev_new;
    raw_hist.push_back(btn);
    start_hist.push_back(start);
  endfunction

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("state", 8'(state), 8'(code_of(m_state)));
    check_eq("state_changed", 8'(state_changed), 8'(m_changed));
    if (state_changed) pulses++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_eq("rst_state", 8'(state), 8'h01);
    check_eq("rst_changed", 8'(state_changed), 8'h00);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic press(input int b, input int hold, input int gap);
    btn[b] = 1'b1;
    repeat (hold) step();
    btn[b] = 1'b0;
    repeat (gap) step();
  endtask

  initial begin
    model_reset();
    // Reset and Start
    do_reset();
    start = 1'b1;
    pulses = 0;
    repeat (6) step();
    check_eq("idle_state", 8'(state), 8'h01);
    check_eq("idle_pulses", 8'(pulses), 8'h00);

    // Count press latency: event at edge 2+D, state at edge 3+D
    pulses = 0;
    btn[1] = 1'b1;
    repeat (6) step();
    check_eq("count_pre", 8'(state), 8'h01);
    step();
    check_eq("count_lat", 8'(state), 8'h02);
    check_eq("count_pulse", 8'(state_changed), 8'h01);
    repeat (3) step();
    btn[1] = 1'b0;
    repeat (8) step();
    check_eq("count_once", 8'(pulses), 8'h01);

    // Bounce on Pause is filtered
    pulses = 0;
    btn[2] = 1'b1; step();
    btn[2] = 1'b0; step();
    btn[2] = 1'b1; step();
    btn[2] = 1'b0; step();
    btn[2] = 1'b1; repeat (3) step();
    btn[2] = 1'b0; repeat (8) step();
    check_eq("bounce_state", 8'(state), 8'h02);
    check_eq("bounce_pulses", 8'(pulses), 8'h00);

    // Mode sequence
    press(2, 6, 8); check_eq("seq_pause", 8'(state), 8'h03);
    press(1, 6, 8); check_eq("seq_resume", 8'(state), 8'h02);
    press(3, 6, 8); check_eq("seq_stop", 8'(state), 8'h04);
    pulses = 0;
    press(1, 6, 8); check_eq("stop_terminal", 8'(state), 8'h04);
    check_eq("stop_no_pulse", 8'(pulses), 8'h00);
    press(0, 6, 8); check_eq("seq_reset", 8'(state), 8'h01);

    // Simultaneous Pause + Stop from COUNT
    press(1, 6, 8);
    pulses = 0;
    btn = 4'b1100;
    repeat (6) step();
    btn = 4'b0000;
    repeat (8) step();
    check_eq("simul_state", 8'(state), 8'h04);
    check_eq("simul_pulses", 8'(pulses), 8'h01);

    // Start gating
    press(0, 6, 8);
    press(1, 6, 8);
    press(2, 6, 8);
    check_eq("gate_pause", 8'(state), 8'h03);
    start = 1'b0;
    repeat (3) step();
    check_eq("start_drop", 8'(state), 8'h01);
    press(1, 6, 8);
    check_eq("gate_count", 8'(state), 8'h01);
    btn[1] = 1'b1;
    repeat (8) step();
    start = 1'b1;
    repeat (10) step();
    btn[1] = 1'b0;
    repeat (8) step();
    check_eq("held_at_start", 8'(state), 8'h01);

    // Reset mid-press: the held button is debounced again from scratch
    btn[1] = 1'b1;
    repeat (2) step();
    do_reset();
    repeat (10) step();
    check_eq("rst_midpress", 8'(state), 8'h02);
    btn[1] = 1'b0;
    repeat (8) step();

    // Random activity
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, (b == 0) ? 15 : 5) == 0) btn[b] = ~btn[b];
      end
      if ($urandom_range(0, start ? 79 : 19) == 0) start = ~start;
      if ($urandom_range(0, 999) == 0) do_reset();
      else step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
